traffic_lane: RTL and testbench

Generates and scrolls one row of cars across the LED playfield, paced by a slow game tick. It consumes `difficulty` and `reset_playfield` from the win/lose stage. Higher difficulty makes cars scroll faster and appear more often. The row is cleared whenever the playfield resets, and collision logic downstream reads `lane` directly.

---
 rtl/traffic_lane.sv | 106 ++++++++++
 tb/tb_traffic_lane.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lane.sv
// One scrolling row of cars for the LED playfield: a paced shift register fed by
// an LFSR car generator whose speed and density follow the difficulty level.
module traffic_lane #(
    parameter int         WIDTH       = 16,
    parameter int         DIR         = 0,
    parameter int         BASE_PERIOD = 8,
    parameter int         STEP        = 1,
    parameter int         MIN_PERIOD  = 2,
    parameter logic [7:0] SEED        = 8'hA5,
    parameter int         MAX_RUN     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             reset_playfield,
    input  logic [2:0]       difficulty,
    output logic [WIDTH-1:0] lane,
    output logic             shift_strobe
);

    localparam int               RUN_W    = (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1);
    localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [10:0]      SPAN     = 11'(BASE_PERIOD - MIN_PERIOD);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);

    // Maximal-length taps 7,5,4,3: a nonzero state never maps to zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    logic [WIDTH-1:0] lane_r;
    logic [7:0]       div_cnt_r;
    logic [7:0]       lfsr_r;
    logic [RUN_W-1:0] run_cnt_r;
    logic             shift_strobe_r;

    logic [10:0]      step_prod_s;
    logic [7:0]       period_s;
    logic [3:0]       density_s;
    logic             shift_s;
    logic             enter_s;
    logic [WIDTH-1:0] next_lane_s;

    // Period and density from difficulty; the period saturates at its floor.
    always_comb begin
        step_prod_s = 11'(STEP) * {8'd0, difficulty};
        if (step_prod_s >= SPAN) begin
            period_s = 8'(MIN_PERIOD);
        end else begin
            period_s = 8'(11'(BASE_PERIOD) - step_prod_s);
        end
        if (difficulty >= 3'd4) begin
            density_s = 4'd6;
        end else begin
            density_s = {1'b0, difficulty} + 4'd2;
        end
    end

    // Shift decision and the bit entering the row; a full run forces a gap.
    always_comb begin
        shift_s = tick && (div_cnt_r >= (period_s - 8'd1));
        if (run_cnt_r == RUN_MAX) begin
            enter_s = 1'b0;
        end else begin
            enter_s = ({1'b0, lfsr_r[2:0]} < density_s);
        end
        if (DIR == 0) begin
            next_lane_s = {enter_s, lane_r[WIDTH-1:1]};
        end else begin
            next_lane_s = {lane_r[WIDTH-2:0], enter_s};
        end
    end

    // Lane state; a playfield clear keeps the LFSR running so rounds differ.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_r         <= {WIDTH{1'b0}};
            div_cnt_r      <= 8'd0;
            run_cnt_r      <= {RUN_W{1'b0}};
            shift_strobe_r <= 1'b0;
            lfsr_r         <= SEED_EFF;
        end else if (reset_playfield) begin
            lane_r         <= {WIDTH{1'b0}};
            div_cnt_r      <= 8'd0;
            run_cnt_r      <= {RUN_W{1'b0}};
            shift_strobe_r <= 1'b0;
        end else if (shift_s) begin
            lane_r         <= next_lane_s;
            div_cnt_r      <= 8'd0;
            run_cnt_r      <= enter_s ? (run_cnt_r + RUN_W'(1)) : {RUN_W{1'b0}};
            lfsr_r         <= lfsr_next(lfsr_r);
            shift_strobe_r <= 1'b1;
        end else begin
            if (tick) begin
                div_cnt_r <= div_cnt_r + 8'd1;
            end else begin
                div_cnt_r <= div_cnt_r;
            end
            shift_strobe_r <= 1'b0;
        end
    end

    assign lane         = lane_r;
    assign shift_strobe = shift_strobe_r;

endmodule

// File: tb/tb_traffic_lane.sv
// Directed bench for traffic_lane: pacing, difficulty scaling, LFSR car stream,
// playfield clear, sparse ticks and the reversed-direction 8-wide variant.
module tb_traffic_lane;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        tick8;
    logic        reset_playfield;
    logic [2:0]  difficulty;
    logic [15:0] lane;
    logic        shift_strobe;
    logic [7:0]  lane8;
    logic        shift_strobe8;

    always #5 clk = ~clk;

    traffic_lane dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .reset_playfield(reset_playfield),
        .difficulty     (difficulty),
        .lane           (lane),
        .shift_strobe   (shift_strobe)
    );

    traffic_lane #(.WIDTH(8), .DIR(1)) dut8 (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick8),
        .reset_playfield(1'b0),
        .difficulty     (3'd7),
        .lane           (lane8),
        .shift_strobe   (shift_strobe8)
    );

    typedef struct {
        logic [15:0] lane;
        int          div;
        logic [7:0]  lfsr;
        int          run;
        logic        strobe;
    } model_t;

    model_t m;
    model_t m8;
    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ones   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    // Reference behaviour with BASE_PERIOD=8, STEP=1, MIN_PERIOD=2, MAX_RUN=2, SEED=A5.
    function automatic model_t mstep(model_t s, bit rst, bit rp, bit tk, int d, bit dir, int w);
        model_t n;
        int per;
        int dens;
        bit e;
        n    = s;
        per  = (d >= 6) ? 2 : 8 - d;
        dens = (2 + d > 6) ? 6 : 2 + d;
        if (rst) begin
            n.lane = 16'h0; n.div = 0; n.run = 0; n.strobe = 1'b0; n.lfsr = 8'hA5;
        end else if (rp) begin
            n.lane = 16'h0; n.div = 0; n.run = 0; n.strobe = 1'b0;
        end else if (tk && s.div >= per - 1) begin
            e = (s.run == 2) ? 1'b0 : (int'(s.lfsr[2:0]) < dens);
            if (dir) n.lane = ((s.lane << 1) | 16'(e)) & ((16'd1 << w) - 16'd1);
            else     n.lane = (s.lane >> 1) | (16'(e) << (w - 1));
            n.run    = e ? s.run + 1 : 0;
            n.lfsr   = {s.lfsr[6:0], ^(s.lfsr & 8'hB8)};
            n.div    = 0;
            n.strobe = 1'b1;
        end else begin
            n.div    = tk ? s.div + 1 : s.div;
            n.strobe = 1'b0;
        end
        return n;
    endfunction

    task automatic step();
        m  = mstep(m, reset, reset_playfield, tick, int'(difficulty), 1'b0, 16);
        m8 = mstep(m8, reset, 1'b0, tick8, 7, 1'b1, 8);
        if (reset || reset_playfield) ones = 0;
        @(posedge clk);
        #1;
        cyc++;
        check("lane", 32'(lane), 32'(m.lane));
        check("strobe", 32'(shift_strobe), 32'(m.strobe));
        check("lane8", 32'(lane8), 32'(m8.lane[7:0]));
        check("strobe8", 32'(shift_strobe8), 32'(m8.strobe));
        if (shift_strobe) begin
            if (lane[15]) ones++;
            else ones = 0;
            check("gap_rule", 32'(ones <= 2), 32'd1);
        end
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!shift_strobe && n < 40);
        if (!shift_strobe) check("strobe_timeout", 32'(shift_strobe), 32'd1);
    endtask

    initial begin
        int n;
        int first_s;
        int second_s;
        int nstrobes;
        int cnt;
        int guard;
        bit found;
        m  = '{16'h0, 0, 8'h0, 0, 1'b0};
        m8 = '{16'h0, 0, 8'h0, 0, 1'b0};
        reset = 1'b1; tick = 1'b0; tick8 = 1'b0; reset_playfield = 1'b0; difficulty = 3'd0;
        step();
        step();
        check("rst_lane", 32'(lane), 32'h0);
        check("rst_strobe", 32'(shift_strobe), 32'h0);

        reset = 1'b0; tick = 1'b1; tick8 = 1'b1;
        wait_strobe(n); check("p0_first", 32'(n), 32'd8);
        wait_strobe(n); check("p0_gap", 32'(n), 32'd8);

        difficulty = 3'd3;
        wait_strobe(n); check("p3_a", 32'(n), 32'd5);
        wait_strobe(n); check("p3_b", 32'(n), 32'd5);
        difficulty = 3'd7;
        wait_strobe(n); check("p7_a", 32'(n), 32'd2);
        wait_strobe(n); check("p7_b", 32'(n), 32'd2);

        // Raise the level with the divider sitting at 5.
        difficulty = 3'd0;
        wait_strobe(n); check("p0_again", 32'(n), 32'd8);
        repeat (5) step();
        difficulty = 3'd7;
        wait_strobe(n); check("mid_raise", 32'(n), 32'd1);

        for (int i = 0; i < 300; i++) begin
            wait_strobe(n);
            check("p7_run", 32'(n), 32'd2);
        end

        // Clear the playfield on a tick that would have shifted.
        step();
        reset_playfield = 1'b1;
        step();
        check("clr_lane", 32'(lane), 32'h0);
        check("clr_strobe", 32'(shift_strobe), 32'h0);
        reset_playfield = 1'b0;
        wait_strobe(n); check("clr_period", 32'(n), 32'd2);
        repeat (10) wait_strobe(n);

        // Sparse ticks at level 0.
        difficulty = 3'd0;
        first_s = -1; second_s = -1; nstrobes = 0;
        for (int i = 0; i < 80; i++) begin
            tick = (i % 4 == 0);
            step();
            if (shift_strobe) begin
                nstrobes++;
                if (first_s < 0) first_s = i;
                else second_s = i;
            end
        end
        tick = 1'b1;
        check("sparse_count", 32'(nstrobes), 32'd2);
        check("sparse_first", 32'(first_s), 32'd28);
        check("sparse_gap", 32'(second_s - first_s), 32'd32);

        // Reset mid-count aborts the count.
        repeat (3) step();
        reset = 1'b1;
        step();
        check("midrst_lane", 32'(lane), 32'h0);
        reset = 1'b0;
        wait_strobe(n); check("midrst_period", 32'(n), 32'd8);

        // DIR=1: a car entering bit 0 reaches bit 7 seven shifts later.
        found = 1'b0; guard = 0;
        while (!found && guard < 200) begin
            step();
            guard++;
            if (m8.strobe && m8.lane[0]) found = 1'b1;
        end
        check("car_entered", 32'(lane8[0]), 32'd1);
        cnt = 0; guard = 0;
        while (cnt < 7 && guard < 100) begin
            step();
            guard++;
            if (shift_strobe8) cnt++;
        end
        check("car_at_msb", 32'(lane8[7]), 32'd1);
        guard = 0;
        do begin
            step();
            guard++;
        end while (!shift_strobe8 && guard < 10);
        check("car_dropped", 32'(lane8[7]), 32'(m8.lane[7]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
